// File: rtl/rom_load_ctrl.sv
// Loads a word stream into the ROM bank, re-reads the written range and compares checksums.
// Latency: one write per accepted word (registered, next cycle); verify costs 1+RD_LAT cycles/word.
// Backpressure: s_ready is high only in WRITE while words remain; abort drops it the next cycle.
module rom_load_ctrl #(
  parameter int         RD_LAT     = 1,
  parameter logic [1:0] MODE_READ  = 2'b00,
  parameter logic [1:0] MODE_WRITE = 2'b01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        abort,
  input  logic [10:0] base_addr,
  input  logic [11:0] length,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic [10:0] rom_column_id,
  output logic [3:0]  rom_read_id,
  output logic [15:0] rom_in,
  output logic [1:0]  rom_mode,
  input  logic [15:0] rom_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_VISSUE, S_VWAIT, S_CHECK
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic [10:0] base_q, base_d;
  logic [11:0] len_q, len_d;
  logic [11:0] cnt_q, cnt_d;
  logic [15:0] wsum_q, wsum_d;
  logic [15:0] rsum_q, rsum_d;
  logic [1:0]  lat_q, lat_d;
  logic [10:0] wcol_q, wcol_d;
  logic [15:0] in_q, in_d;
  logic [1:0]  mode_q, mode_d;
  logic        done_q, done_d;
  logic [1:0]  status_q, status_d;

  logic len_ok;
  logic hs;
  logic lat_last;

  assign len_ok   = (length != 12'd0) && (length <= 12'd2048);
  assign hs       = s_valid && s_ready;
  assign lat_last = (lat_q == LAT_LAST);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort pulls any active state back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && len_ok) state_d = S_WRITE;
      S_WRITE:  if (abort) state_d = S_IDLE;
                else if (cnt_q == 12'd0) state_d = S_VISSUE;
      S_VISSUE: state_d = abort ? S_IDLE : S_VWAIT;
      S_VWAIT:  if (abort) state_d = S_IDLE;
                else if (lat_last) state_d = (cnt_q == 12'd1) ? S_CHECK : S_VISSUE;
      S_CHECK:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: verify phases present the read address directly, otherwise the last write address
  always_comb begin
    s_ready       = (state_q == S_WRITE) && (cnt_q != 12'd0);
    busy          = (state_q != S_IDLE);
    rom_column_id = ((state_q == S_VISSUE) || (state_q == S_VWAIT)) ? addr_q : wcol_q;
    rom_read_id   = rom_column_id[10:7];
    rom_in        = in_q;
    rom_mode      = mode_q;
    done          = done_q;
    status        = status_q;
  end

  // Datapath next-state: address/count sequencing, checksums, write pulse, status
  always_comb begin
    addr_d   = addr_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wsum_d   = wsum_q;
    rsum_d   = rsum_q;
    lat_d    = lat_q;
    wcol_d   = wcol_q;
    in_d     = in_q;
    mode_d   = MODE_READ;
    done_d   = 1'b0;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            addr_d   = base_addr;
            base_d   = base_addr;
            len_d    = length;
            cnt_d    = length;
            wsum_d   = 16'd0;
            rsum_d   = 16'd0;
            status_d = 2'b00;
          end else begin
            status_d = 2'b11;
            done_d   = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (abort) begin
          status_d = 2'b10;
          done_d   = 1'b1;
        end else if (hs) begin
          wcol_d = addr_q;
          in_d   = s_data;
          mode_d = MODE_WRITE;
          addr_d = addr_q + 11'd1;
          wsum_d = wsum_q + s_data;
          cnt_d  = cnt_q - 12'd1;
        end else if (cnt_q == 12'd0) begin
          addr_d = base_q;
          cnt_d  = len_q;
          lat_d  = 2'd0;
        end
      end
      S_VISSUE: begin
        if (abort) begin
          status_d = 2'b10;
          done_d   = 1'b1;
        end else begin
          lat_d = 2'd0;
        end
      end
      S_VWAIT: begin
        if (abort) begin
          status_d = 2'b10;
          done_d   = 1'b1;
        end else if (lat_last) begin
          rsum_d = rsum_q + rom_out;
          addr_d = addr_q + 11'd1;
          cnt_d  = cnt_q - 12'd1;
          lat_d  = 2'd0;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_CHECK: begin
        status_d = abort ? 2'b10 : ((rsum_q == wsum_q) ? 2'b00 : 2'b01);
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wsum_q   <= '0;
      rsum_q   <= '0;
      lat_q    <= '0;
      wcol_q   <= '0;
      in_q     <= '0;
      mode_q   <= MODE_READ;
      done_q   <= 1'b0;
      status_q <= 2'b00;
    end else begin
      addr_q   <= addr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wsum_q   <= wsum_d;
      rsum_q   <= rsum_d;
      lat_q    <= lat_d;
      wcol_q   <= wcol_d;
      in_q     <= in_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl with a behavioural ROM bank (1-cycle read latency).
module tb_rom_load_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, abort;
  logic [10:0] base_addr;
  logic [11:0] length;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic [10:0] rom_column_id;
  logic [3:0]  rom_read_id;
  logic [15:0] rom_in;
  logic [1:0]  rom_mode;
  logic [15:0] rom_out;
  logic        busy, done;
  logic [1:0]  status;

  int vectors = 0;
  int errors  = 0;

  // ROM bank model and observation logs
  logic [15:0] mem [0:2047];
  logic        corrupt_en = 1'b0;
  logic [10:0] corrupt_addr = '0;
  logic [15:0] img [0:15];
  logic [10:0] wr_addr [0:31];
  logic [15:0] wr_data [0:31];
  logic [3:0]  wr_rid  [0:31];
  int          wr_cyc  [0:31];
  int          wr_n = 0;
  int          done_n = 0;
  int          cyc = 0;

  rom_load_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rom_column_id(rom_column_id), .rom_read_id(rom_read_id),
    .rom_in(rom_in), .rom_mode(rom_mode), .rom_out(rom_out),
    .busy(busy), .done(done), .status(status)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (rom_mode == 2'b01) mem[rom_column_id] <= rom_in;
    rom_out <= mem[rom_column_id] ^ ((corrupt_en && rom_column_id == corrupt_addr) ? 16'h0004 : 16'h0000);
  end

  always @(negedge CLK) begin
    if (rom_mode == 2'b01 && wr_n < 32) begin
      wr_addr[wr_n] = rom_column_id;
      wr_data[wr_n] = rom_in;
      wr_rid[wr_n]  = rom_read_id;
      wr_cyc[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
    if (done) done_n = done_n + 1;
  end

  task automatic clear_logs();
    wr_n = 0;
    done_n = 0;
  endtask

  task automatic pulse_start(input logic [10:0] b, input logic [11:0] l);
    @(posedge CLK); #1;
    base_addr = b; length = l; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Drive n words of img[]; toggle=1 inserts an idle cycle between words
  task automatic stream(input int n, input bit toggle);
    int idx = 0;
    int k = 0;
    bit h;
    while (idx < n && k < 200) begin
      s_valid = toggle ? (k % 2 == 0) : 1'b1;
      s_data  = img[idx];
      @(negedge CLK);
      h = s_valid && s_ready;
      @(posedge CLK); #1;
      if (h) idx++;
      k++;
    end
    s_valid = 1'b0;
    if (idx != n) begin
      errors++; vectors++;
      $display("FAIL stream_timeout accepted=%0d required=%0d", idx, n);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_n == 0 && k < 300) begin
      @(negedge CLK);
      k++;
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if (done_n !== 1) begin
      errors++;
      $display("FAIL %s_done_count got=%0d exp=1", name, done_n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    vectors++; if (s_ready !== 1'b0)        begin errors++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    vectors++; if (rom_mode !== 2'b00)      begin errors++; $display("FAIL rst_mode got=%b exp=00", rom_mode); end
    vectors++; if (rom_column_id !== 11'd0) begin errors++; $display("FAIL rst_col got=%h exp=0", rom_column_id); end
    vectors++; if (rom_read_id !== 4'd0)    begin errors++; $display("FAIL rst_rid got=%h exp=0", rom_read_id); end
    vectors++; if (rom_in !== 16'd0)        begin errors++; $display("FAIL rst_in got=%h exp=0", rom_in); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || status !== 2'b00)
      begin errors++; $display("FAIL rst_flags got=%b%b%b exp=0000", busy, done, status); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [0:3];
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
    for (int i = 0; i < 4; i++) img[i] = exp_d[i];
    clear_logs();
    pulse_start(11'h010, 12'd4);
    stream(4, 1'b0);
    wait_done("b2b");
    vectors++; if (wr_n !== 4) begin errors++; $display("FAIL b2b_writes got=%0d exp=4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr_addr[i] !== 11'h010 + 11'(i) || wr_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL b2b_write%0d got=%h/%h exp=%h/%h", i, wr_addr[i], wr_data[i], 11'h010 + 11'(i), exp_d[i]);
      end
    end
    vectors++; if (wr_cyc[3] - wr_cyc[0] !== 3) begin errors++; $display("FAIL b2b_consecutive span=%0d exp=3", wr_cyc[3] - wr_cyc[0]); end
    vectors++; if (status !== 2'b00) begin errors++; $display("FAIL b2b_status got=%b exp=00", status); end
  endtask

  task automatic test_wrap();
    img[0] = 16'hA001; img[1] = 16'hA002; img[2] = 16'hA003;
    clear_logs();
    pulse_start(11'h7FE, 12'd3);
    stream(3, 1'b0);
    wait_done("wrap");
    vectors++;
    if (wr_n !== 3 || wr_addr[0] !== 11'h7FE || wr_addr[1] !== 11'h7FF || wr_addr[2] !== 11'h000) begin
      errors++; $display("FAIL wrap_addr got=%0d:%h,%h,%h exp=3:7fe,7ff,000", wr_n, wr_addr[0], wr_addr[1], wr_addr[2]);
    end
    vectors++;
    if (wr_rid[0] !== 4'd15 || wr_rid[1] !== 4'd15 || wr_rid[2] !== 4'd0) begin
      errors++; $display("FAIL wrap_rid got=%0d,%0d,%0d exp=15,15,0", wr_rid[0], wr_rid[1], wr_rid[2]);
    end
    vectors++; if (status !== 2'b00) begin errors++; $display("FAIL wrap_status got=%b exp=00", status); end
  endtask

  task automatic test_toggle_valid();
    for (int i = 0; i < 8; i++) img[i] = 16'h0100 * 16'(i + 1) + 16'h0005;
    clear_logs();
    pulse_start(11'h200, 12'd8);
    stream(8, 1'b1);
    wait_done("toggle");
    vectors++; if (wr_n !== 8) begin errors++; $display("FAIL toggle_writes got=%0d exp=8", wr_n); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (wr_data[i] !== 16'h0100 * 16'(i + 1) + 16'h0005 || wr_addr[i] !== 11'h200 + 11'(i)) begin
        errors++; $display("FAIL toggle_word%0d got=%h@%h exp=%h@%h", i, wr_data[i], wr_addr[i],
                           16'h0100 * 16'(i + 1) + 16'h0005, 11'h200 + 11'(i));
      end
    end
    vectors++; if (status !== 2'b00) begin errors++; $display("FAIL toggle_status got=%b exp=00", status); end
  endtask

  task automatic test_checksum_mismatch();
    img[0] = 16'h0001; img[1] = 16'h0002; img[2] = 16'h0003; img[3] = 16'h0004;
    corrupt_en = 1'b1; corrupt_addr = 11'h302;
    clear_logs();
    pulse_start(11'h300, 12'd4);
    stream(4, 1'b0);
    wait_done("csum");
    corrupt_en = 1'b0;
    vectors++; if (status !== 2'b01) begin errors++; $display("FAIL csum_status got=%b exp=01", status); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL csum_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) img[i] = 16'hB000 + 16'(i);
    clear_logs();
    pulse_start(11'h400, 12'd5);
    stream(2, 1'b0);
    s_valid = 1'b1; s_data = img[2]; abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0; s_valid = 1'b0;
    @(negedge CLK);
    vectors++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b s_ready=%b exp=0,0", busy, s_ready); end
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done got=%b exp=1", done); end
    vectors++; if (status !== 2'b10) begin errors++; $display("FAIL abort_status got=%b exp=10", status); end
    vectors++; if (rom_mode !== 2'b00) begin errors++; $display("FAIL abort_mode got=%b exp=00", rom_mode); end
    repeat (10) @(negedge CLK);
    vectors++; if (wr_n !== 2) begin errors++; $display("FAIL abort_writes got=%0d exp=2", wr_n); end
    // abort while idle must not disturb the held status
    abort = 1'b1; @(negedge CLK); abort = 1'b0; @(negedge CLK);
    vectors++; if (done_n !== 1 || status !== 2'b10) begin errors++; $display("FAIL abort_idle_ignored done_n=%0d status=%b exp=1,10", done_n, status); end
  endtask

  task automatic test_bad_length();
    logic [11:0] bad [0:1];
    bad[0] = 12'd0; bad[1] = 12'd2049;
    for (int i = 0; i < 2; i++) begin
      clear_logs();
      pulse_start(11'h050, bad[i]);
      @(negedge CLK);
      vectors++; if (done !== 1'b1 || status !== 2'b11) begin errors++; $display("FAIL badlen%0d got=done%b st%b exp=done1 st11", i, done, status); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL badlen%0d_busy got=%b exp=0", i, busy); end
      repeat (5) @(negedge CLK);
      vectors++; if (wr_n !== 0 || done_n !== 1) begin errors++; $display("FAIL badlen%0d_quiet writes=%0d dones=%0d exp=0,1", i, wr_n, done_n); end
    end
  endtask

  task automatic test_reset_mid_verify();
    for (int i = 0; i < 4; i++) img[i] = 16'hC0DE + 16'(i);
    clear_logs();
    pulse_start(11'h5A0, 12'd4);
    stream(4, 1'b0);
    repeat (3) @(negedge CLK);
    vectors++; if (busy !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL midverify_busy busy=%b s_ready=%b exp=1,0", busy, s_ready); end
    #1 RST = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || status !== 2'b00 || rom_mode !== 2'b00 ||
        rom_column_id !== 11'd0 || rom_read_id !== 4'd0 || rom_in !== 16'd0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL midverify_reset busy=%b done=%b st=%b mode=%b col=%h in=%h exp=all zero",
                         busy, done, status, rom_mode, rom_column_id, rom_in);
    end
    @(negedge CLK); RST = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++; if (busy !== 1'b0 || done_n !== 0) begin errors++; $display("FAIL midverify_after busy=%b dones=%0d exp=0,0", busy, done_n); end
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    s_valid = 1'b0; s_data = '0;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_toggle_valid();
    test_checksum_mismatch();
    test_abort();
    test_bad_length();
    test_reset_mid_verify();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
